// File: rtl/load_store_unit.sv
// Load/store unit: sits between the core request port and a byte-addressed
// dataMemory. Aligned accesses use a single memory cycle. Misaligned accesses
// are split into byte beats and reassembled. Invalid requests get an error response.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  input  logic        reqWrite,
  input  logic [2:0]  reqFunct3,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqWriteData,
  output logic        reqReady,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        respErr,
  output logic [31:0] address,
  output logic [31:0] writeData,
  output logic [2:0]  funct3,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] readData
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_next;
  logic        wr_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  size_q;
  logic        mis_q;
  logic [1:0]  beat_q;
  logic [31:0] load_q;
  logic [31:0] result_q;
  logic        err_q;

  logic [2:0]  req_size;
  logic [32:0] req_end;
  logic        req_err;
  logic        req_mis;
  logic        last_beat;
  logic [31:0] assembled;
  logic [31:0] raw;
  logic [31:0] extended;
  logic [31:0] wshift;

  // Decode the incoming request: access size, error conditions, misalignment
  always_comb begin
    req_size = 3'd1;
    case (reqFunct3)
      3'b001, 3'b101: req_size = 3'd2;
      3'b010:         req_size = 3'd4;
      default:        req_size = 3'd1;
    endcase
    // 33-bit sum so an access running past 0xFFFFFFFF cannot wrap into range
    req_end = {1'b0, reqAddress} + {30'b0, req_size} - 33'd1;
    req_err = (reqFunct3 == 3'b011) || (reqFunct3 == 3'b110) || (reqFunct3 == 3'b111) ||
              (reqWrite && reqFunct3[2]) || (req_end > 33'h0_0000_0FFF);
    req_mis = ((req_size == 3'd2) && reqAddress[0]) ||
              ((req_size == 3'd4) && (reqAddress[1:0] != 2'b00));
  end

  // Beat bookkeeping and load-result assembly/extension
  always_comb begin
    last_beat = !mis_q || ({1'b0, beat_q} == (size_q - 3'd1));
    assembled = load_q;
    case (beat_q)
      2'd0: assembled[7:0]   = readData[7:0];
      2'd1: assembled[15:8]  = readData[7:0];
      2'd2: assembled[23:16] = readData[7:0];
      2'd3: assembled[31:24] = readData[7:0];
      default: assembled = load_q;
    endcase
    raw = mis_q ? assembled : readData;
    case (f3_q)
      3'b000:  extended = {{24{raw[7]}}, raw[7:0]};
      3'b001:  extended = {{16{raw[15]}}, raw[15:0]};
      3'b010:  extended = raw;
      3'b100:  extended = {24'b0, raw[7:0]};
      3'b101:  extended = {16'b0, raw[15:0]};
      default: extended = '0;
    endcase
    wshift = wdata_q >> {beat_q, 3'b000};
  end

  // State register plus latched request, beat counter and result
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_q     <= 1'b0;
      f3_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      mis_q    <= 1'b0;
      beat_q   <= '0;
      load_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (reqValid) begin
            wr_q     <= reqWrite;
            f3_q     <= reqFunct3;
            addr_q   <= reqAddress;
            wdata_q  <= reqWriteData;
            size_q   <= req_size;
            mis_q    <= req_mis;
            beat_q   <= '0;
            err_q    <= req_err;
            result_q <= '0;
          end
        end
        ACCESS: begin
          if (mis_q) load_q <= assembled;
          if (last_beat) begin
            beat_q   <= '0;
            result_q <= wr_q ? '0 : extended;
          end else begin
            beat_q <= beat_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic and all outputs
  always_comb begin
    state_next = state;
    reqReady   = (state == IDLE);
    respValid  = 1'b0;
    respData   = '0;
    respErr    = 1'b0;
    address    = '0;
    writeData  = '0;
    funct3     = '0;
    MemWrite   = 1'b0;
    MemRead    = 1'b0;
    case (state)
      IDLE: begin
        if (reqValid) state_next = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        if (last_beat) state_next = RESP;
        // Strobes are gated by rst so a beat in flight when reset arrives is
        // never written: reset aborts before the memory samples MemWrite.
        if (!rst) begin
          MemRead   = !wr_q;
          MemWrite  = wr_q;
          address   = addr_q + {30'b0, beat_q};
          funct3    = mis_q ? (wr_q ? 3'b000 : 3'b100) : f3_q;
          writeData = wr_q ? (mis_q ? {24'b0, wshift[7:0]} : wdata_q) : '0;
        end
      end
      RESP: begin
        state_next = IDLE;
        respValid  = 1'b1;
        respData   = result_q;
        respErr    = err_q;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a byte-addressed memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid;
  logic        reqWrite;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddress;
  logic [31:0] reqWriteData;
  logic        reqReady;
  logic        respValid;
  logic [31:0] respData;
  logic        respErr;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [2:0]  funct3;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] readData;

  logic [7:0]  mem [0:4095] = '{default: 8'h00};
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  logic [11:0] ra;

  int n_cmp = 0;
  int n_bad = 0;

  load_store_unit dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqWrite(reqWrite),
    .reqFunct3(reqFunct3), .reqAddress(reqAddress), .reqWriteData(reqWriteData),
    .reqReady(reqReady), .respValid(respValid), .respData(respData), .respErr(respErr),
    .address(address), .writeData(writeData), .funct3(funct3),
    .MemWrite(MemWrite), .MemRead(MemRead), .readData(readData)
  );

  always #5 clk = ~clk;

  // Combinational little-endian read of four bytes starting at address
  always_comb begin
    ra = address[11:0];
    readData = {mem[ra + 12'd3], mem[ra + 12'd2], mem[ra + 12'd1], mem[ra]};
  end

  // Memory writes by funct3 width; idle cycles may preload bytes
  always @(posedge clk) begin
    if (MemWrite) begin
      case (funct3)
        3'b000: mem[address[11:0]] <= writeData[7:0];
        3'b001: begin
          mem[address[11:0]]         <= writeData[7:0];
          mem[address[11:0] + 12'd1] <= writeData[15:8];
        end
        3'b010: begin
          mem[address[11:0]]         <= writeData[7:0];
          mem[address[11:0] + 12'd1] <= writeData[15:8];
          mem[address[11:0] + 12'd2] <= writeData[23:16];
          mem[address[11:0] + 12'd3] <= writeData[31:24];
        end
        default: ;
      endcase
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issue one request, wait (bounded) for the response and check it
  task automatic do_req(input string tag, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_data, input logic exp_err,
                        input int exp_lat, input int exp_rd, input int exp_wr);
    int lat, rd, wr;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = w; reqFunct3 = f3; reqAddress = a; reqWriteData = d;
    check({tag, "/ready"}, {31'b0, reqReady}, 32'd1);
    @(posedge clk); #1;
    reqValid = 1'b0; reqAddress = 32'hFFFF_FFFF; reqWriteData = 32'h5A5A_5A5A;
    lat = 1; rd = 0; wr = 0;
    while (!respValid && lat < 30) begin
      if (MemRead) rd++;
      if (MemWrite) wr++;
      @(posedge clk); #1;
      lat++;
    end
    if (!respValid) lat = -1;
    check({tag, "/lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "/data"}, respData, exp_data);
    check({tag, "/err"}, {31'b0, respErr}, {31'b0, exp_err});
    check({tag, "/rd"}, 32'(rd), 32'(exp_rd));
    check({tag, "/wr"}, 32'(wr), 32'(exp_wr));
    @(posedge clk); #1;
    check({tag, "/post"}, {respValid, respErr, reqReady, MemRead, MemWrite, 27'b0},
          {5'b00100, 27'b0});
    check({tag, "/postdata"}, respData, 32'h0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqFunct3 = '0;
    reqAddress = '0; reqWriteData = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst/ready", {31'b0, reqReady}, 32'd1);
    check("rst/resp", {29'b0, respValid, respErr, MemRead | MemWrite}, 32'd0);
    check("rst/respData", respData, 32'd0);
    check("rst/address", address, 32'd0);
    check("rst/writeData", writeData, 32'd0);
    check("rst/funct3", {29'b0, funct3}, 32'd0);
    @(negedge clk); rst = 1'b0;

    poke(12'h100, 8'h11); poke(12'h101, 8'h22); poke(12'h102, 8'h33);
    poke(12'h103, 8'h84); poke(12'h104, 8'hF0);
    poke(12'hFFC, 8'h01); poke(12'hFFD, 8'h02); poke(12'hFFE, 8'h03); poke(12'hFFF, 8'h04);

    do_req("lw100",  1'b0, 3'b010, 32'h100, 32'h0, 32'h8433_2211, 1'b0, 2, 1, 0);
    do_req("lh103",  1'b0, 3'b001, 32'h103, 32'h0, 32'hFFFF_F084, 1'b0, 3, 2, 0);
    do_req("lhu103", 1'b0, 3'b101, 32'h103, 32'h0, 32'h0000_F084, 1'b0, 3, 2, 0);
    do_req("lb103",  1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFF_FF84, 1'b0, 2, 1, 0);
    do_req("lbu103", 1'b0, 3'b100, 32'h103, 32'h0, 32'h0000_0084, 1'b0, 2, 1, 0);

    do_req("sw201", 1'b1, 3'b010, 32'h201, 32'hDEAD_BEEF, 32'h0, 1'b0, 5, 0, 4);
    check("sw201/mem", {mem[12'h204], mem[12'h203], mem[12'h202], mem[12'h201]}, 32'hDEAD_BEEF);
    check("sw201/mem200", {24'b0, mem[12'h200]}, 32'h0);
    do_req("lw201", 1'b0, 3'b010, 32'h201, 32'h0, 32'hDEAD_BEEF, 1'b0, 5, 4, 0);

    do_req("sh300", 1'b1, 3'b001, 32'h300, 32'h1234_ABCD, 32'h0, 1'b0, 2, 0, 1);
    check("sh300/mem", {8'h0, mem[12'h302], mem[12'h301], mem[12'h300]}, 32'h0000_ABCD);
    do_req("lh300", 1'b0, 3'b001, 32'h300, 32'h0, 32'hFFFF_ABCD, 1'b0, 2, 1, 0);
    do_req("sb105", 1'b1, 3'b000, 32'h105, 32'h0000_00A5, 32'h0, 1'b0, 2, 0, 1);
    check("sb105/mem", {mem[12'h106], mem[12'h105], mem[12'h104]}, {8'h00, 8'hA5, 8'hF0});
    do_req("lwFFC", 1'b0, 3'b010, 32'hFFC, 32'h0, 32'h0403_0201, 1'b0, 2, 1, 0);
    do_req("lbFFF", 1'b0, 3'b100, 32'hFFF, 32'h0, 32'h0000_0004, 1'b0, 2, 1, 0);

    do_req("e_lwFFE",  1'b0, 3'b010, 32'hFFE, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("e_lb1000", 1'b0, 3'b000, 32'h1000, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("e_f3_011", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("e_sb100",  1'b1, 3'b100, 32'h100, 32'h0000_0077, 32'h0, 1'b1, 1, 0, 0);
    do_req("e_sh101",  1'b1, 3'b101, 32'h100, 32'h0000_0077, 32'h0, 1'b1, 1, 0, 0);
    do_req("e_wrap",   1'b0, 3'b010, 32'hFFFF_FFFD, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    check("e_sb100/mem", {24'b0, mem[12'h100]}, 32'h11);

    // Request held valid with changing fields: only the IDLE-time one counts
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b0; reqFunct3 = 3'b010; reqAddress = 32'h100; reqWriteData = '0;
    @(posedge clk); #1;
    reqWrite = 1'b1; reqFunct3 = 3'b000; reqAddress = 32'h104; reqWriteData = 32'h0000_0099;
    check("hold/addr", address, 32'h100);
    check("hold/strobe", {30'b0, MemRead, MemWrite}, 32'd2);
    @(posedge clk); #1;
    check("hold/valid", {31'b0, respValid}, 32'd1);
    check("hold/data", respData, 32'h8433_2211);
    reqValid = 1'b0;
    @(posedge clk); #1;
    check("hold/idle", {31'b0, reqReady}, 32'd1);
    check("hold/mem104", {24'b0, mem[12'h104]}, 32'hF0);

    // Reset during beat 2 of a misaligned store
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqFunct3 = 3'b010; reqAddress = 32'h401;
    reqWriteData = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    reqValid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort/beat2addr", address, 32'h403);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort/ready", {31'b0, reqReady}, 32'd1);
    check("abort/outs", {29'b0, respValid, MemWrite, MemRead}, 32'd0);
    check("abort/address", address, 32'd0);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (respValid || MemWrite) seen++;
    end
    check("abort/quiet", 32'(seen), 32'd0);
    check("abort/mem", {mem[12'h404], mem[12'h403], mem[12'h402], mem[12'h401]}, 32'h0000_BEEF);

    // Request presented during reset is not accepted
    @(negedge clk);
    rst = 1'b1; reqValid = 1'b1; reqWrite = 1'b0; reqFunct3 = 3'b010; reqAddress = 32'h100;
    @(posedge clk); #1;
    check("rstreq/ready", {31'b0, reqReady}, 32'd1);
    @(negedge clk);
    rst = 1'b0; reqValid = 1'b0;
    @(posedge clk); #1;
    check("rstreq/idle", {29'b0, reqReady, respValid, MemRead}, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
